// File: rtl/encoder_predictor.sv
// encoder_predictor
// Pops packed sample words from a first-word-fall-through FIFO, unpacks them
// one sample per beat and emits the delta to the previous sample on the
// same line as a signed (DATA_WIDTH+1)-bit residual on an AXI-Stream master.
// Tracks line length and pulses LEN_ERR when a line is not LINE_SAMPLES long.
//
// Ports
//   ACLK, ARESET_N      clock (rising edge), async active-low reset
//   DATA_IN             packed word, sample 0 in the low DATA_WIDTH bits
//   LAST_IN, USER_IN    word ends a line / word starts a frame
//   EMPTY, RD_EN        FIFO empty flag in, pop strobe out
//   M_TDATA/TVALID/TREADY/TUSER/TLAST   residual stream out
//   LEN_ERR             one-cycle pulse after a bad-length line
module encoder_predictor #(
    parameter int DATA_WIDTH       = 16,
    parameter int SAMPLES_PER_WORD = 5,
    parameter int LINE_SAMPLES     = 1920
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET_N,
    input  logic [DATA_WIDTH*SAMPLES_PER_WORD-1:0] DATA_IN,
    input  logic                                   LAST_IN,
    input  logic                                   USER_IN,
    input  logic                                   EMPTY,
    output logic                                   RD_EN,
    output logic [DATA_WIDTH:0]                    M_TDATA,
    output logic                                   M_TVALID,
    input  logic                                   M_TREADY,
    output logic                                   M_TUSER,
    output logic                                   M_TLAST,
    output logic                                   LEN_ERR
);

    localparam int WORD_W = DATA_WIDTH * SAMPLES_PER_WORD;
    localparam int IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
    localparam int CNT_W  = $clog2(LINE_SAMPLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(LINE_SAMPLES);

    logic                  r_run;
    logic [WORD_W-1:0]     r_hold_word;
    logic                  r_hold_last;
    logic                  r_hold_user;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_hold_valid;
    logic                  r_tvalid;
    logic [DATA_WIDTH:0]   r_tdata;
    logic                  r_tuser;
    logic                  r_tlast;
    logic                  r_err_pending;
    logic                  r_len_err;
    logic [DATA_WIDTH-1:0] r_pred;
    logic                  r_line_start;
    logic [CNT_W-1:0]      r_line_cnt;

    logic                  w_out_load;
    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_last_idx;
    logic [DATA_WIDTH-1:0] w_sample;
    logic                  w_is_user;
    logic                  w_is_last;
    logic                  w_first;
    logic [DATA_WIDTH:0]   w_resid;
    logic [CNT_W-1:0]      w_cnt_beat;
    logic                  w_wrap;
    logic                  w_beat_err;

    assign w_out_load = r_hold_valid && (!r_tvalid || M_TREADY);
    assign w_accept   = r_tvalid && M_TREADY;
    assign w_last_idx = (r_idx == LAST_IDX);

    // r_run keeps RD_EN low until the first edge after reset release.
    assign w_rd_en = r_run && !EMPTY && (!r_hold_valid || (w_last_idx && w_out_load));

    assign w_sample  = r_hold_word[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_is_user = r_hold_user && (r_idx == '0);
    assign w_is_last = r_hold_last && w_last_idx;
    assign w_first   = r_line_start || w_is_user;
    assign w_resid   = {1'b0, w_sample} - (w_first ? '0 : {1'b0, r_pred});

    // Line accounting is done when a beat enters the output register. Every
    // loaded beat is accepted before the next one loads (reset clears both),
    // so this count matches the count of accepted beats, and the wrap can
    // restart prediction for the very next sample without extra latency.
    assign w_cnt_beat = (w_first ? '0 : r_line_cnt) + CNT_W'(1);
    assign w_wrap     = w_is_last || (w_cnt_beat == LINE_LEN);
    assign w_beat_err = w_is_last ? (w_cnt_beat != LINE_LEN) : (w_cnt_beat == LINE_LEN);

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_run        <= 1'b0;
            r_hold_word  <= '0;
            r_hold_last  <= 1'b0;
            r_hold_user  <= 1'b0;
            r_idx        <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_rd_en) begin
                r_hold_word  <= DATA_IN;
                r_hold_last  <= LAST_IN;
                r_hold_user  <= USER_IN;
                r_idx        <= '0;
                r_hold_valid <= 1'b1;
            end else if (w_out_load) begin
                if (w_last_idx) begin
                    r_idx        <= '0;
                    r_hold_valid <= 1'b0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_tuser       <= 1'b0;
            r_tlast       <= 1'b0;
            r_err_pending <= 1'b0;
            r_len_err     <= 1'b0;
        end else begin
            r_len_err <= w_accept && r_err_pending;
            if (w_out_load) begin
                r_tvalid      <= 1'b1;
                r_tdata       <= w_resid;
                r_tuser       <= w_is_user;
                r_tlast       <= w_is_last;
                r_err_pending <= w_beat_err;
            end else if (M_TREADY) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_pred       <= '0;
            r_line_start <= 1'b1;
            r_line_cnt   <= '0;
        end else if (w_out_load) begin
            r_pred       <= w_sample;
            r_line_start <= w_wrap;
            r_line_cnt   <= w_wrap ? '0 : w_cnt_beat;
        end
    end

    assign RD_EN    = w_rd_en;
    assign M_TVALID = r_tvalid;
    assign M_TDATA  = r_tdata;
    assign M_TUSER  = r_tuser;
    assign M_TLAST  = r_tlast;
    assign LEN_ERR  = r_len_err;

endmodule
